// File: rtl/data_cache_if.sv
// data_cache_if: core request bus and memory bus of the direct-mapped data cache
interface data_cache_if #(parameter int W = 32);
  logic req, we, inv, stall, mem_req, mem_we, mem_ack;
  logic [W-1:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] be, mem_be;
  modport slave (
    input req, we, addr, wdata, be, inv, mem_rdata, mem_ack,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
  modport master (
    output req, we, addr, wdata, be, inv, mem_rdata, mem_ack,
    input rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/data_cache.sv
// data_cache: direct-mapped one-word-line write-through cache without write-allocate
module data_cache #(
  parameter int W = 32,
  parameter int SETS = 16
) (
  input logic clk,
  input logic rst,
  data_cache_if.slave bus
);
  localparam int IDX = $clog2(SETS);
  localparam int TW = W - IDX - 2;
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t st, nx;
  logic [SETS-1:0] valid;
  logic [TW-1:0] tags [SETS];
  logic [W-1:0] lines [SETS];
  logic [W-1:0] a_q, wd_q;
  logic [3:0] be_q;
  logic done, inv_p, hit, qhit;
  logic [IDX-1:0] idx, qi;
  logic [TW-1:0] tg, qt;
  assign idx = bus.addr[IDX+1:2];
  assign tg = bus.addr[W-1:IDX+2];
  assign qi = a_q[IDX+1:2];
  assign qt = a_q[W-1:IDX+2];
  assign hit = bus.req & valid[idx] & (tags[idx] == tg);
  assign qhit = valid[qi] & (tags[qi] == qt);
  assign bus.stall = !rst & ((st != IDLE) | (bus.req & (bus.we ? !done : !hit)));
  assign bus.rdata = rst ? '0 : lines[idx];
  assign bus.mem_req = st != IDLE;
  assign bus.mem_we = st == WRITE;
  assign bus.mem_addr = a_q & ~W'(3);
  assign bus.mem_wdata = wd_q;
  assign bus.mem_be = st == WRITE ? be_q : 4'hf;
  // next state: a completed store (done) is not re-issued; memory ack ends FILL/WRITE
  always_comb begin
    nx = st;
    if (st == IDLE)
      nx = (bus.req & bus.we & !done) ? WRITE : (bus.req & !bus.we & !hit) ? FILL : IDLE;
    else if (bus.mem_ack)
      nx = IDLE;
  end
  // control state: FSM, store-done flag, invalidate deferred until back in IDLE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      done <= 1'b0;
      inv_p <= 1'b0;
      valid <= '0;
    end else begin
      st <= nx;
      done <= (st == WRITE) & bus.mem_ack;
      inv_p <= (st == IDLE) ? 1'b0 : inv_p | bus.inv;
      if ((st == IDLE) & (bus.inv | inv_p))
        valid <= '0;
      else if ((st == FILL) & bus.mem_ack)
        valid[qi] <= 1'b1;
    end
  // request capture while idle keeps memory outputs stable; line/tag updates on ack
  always_ff @(posedge clk)
    if (st == IDLE) begin
      a_q <= bus.addr;
      wd_q <= bus.wdata;
      be_q <= bus.be;
    end else if ((st == FILL) & bus.mem_ack) begin
      lines[qi] <= bus.mem_rdata;
      tags[qi] <= qt;
    end else if ((st == WRITE) & bus.mem_ack & qhit) begin
      for (int b = 0; b < 4; b++)
        if (be_q[b]) lines[qi][8*b +: 8] <= wd_q[8*b +: 8];
    end
endmodule
